// File: rtl/sc_boot_pkg.sv
// Shared types and constants for the boot loader: the state encoding,
// stream framing sizes and the state decodes used for the status outputs.
package sc_boot_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DRAIN,
    RUN,
    ERR
  } boot_state_t;

  localparam int BOOT_HDR_BYTES  = 2;
  localparam int BOOT_WORD_BYTES = 4;

  function automatic logic boot_rx_ready(input boot_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
  endfunction

  function automatic logic boot_busy(input boot_state_t s);
    return (s != RUN) && (s != ERR);
  endfunction

endpackage

// File: rtl/sc_boot_loader_if.sv
// Byte stream into the loader and instruction-memory write port out of it.
// master: board-side byte source / memory; slave: the boot loader.
interface sc_boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/sc_byte_packer.sv
// Assembles little-endian 32-bit words from accepted payload bytes.
// byte_last flags that the next accepted byte completes a word; the
// completed word appears on word_data with a one-cycle word_valid.
// word_data holds its value between words so it can drive the write data.
module sc_byte_packer
  import sc_boot_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam logic [1:0] LAST_IDX = 2'(BOOT_WORD_BYTES - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  assign byte_last = (byte_cnt == LAST_IDX);

  // Shift lower bytes in from the top; the fourth byte lands as the MSB.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      byte_cnt   <= 2'd0;
      shift_q    <= 24'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
        shift_q  <= 24'd0;
      end else if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_last) begin
          word_data  <= {byte_data, shift_q};
          word_valid <= 1'b1;
        end else begin
          shift_q <= {byte_data, shift_q[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/sc_boot_loader.sv
// Boot sequencer: holds the CPU in reset, loads a counted image from the
// byte stream into instruction memory, then releases the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN adds a trailing 32-bit wrapping
// sum of the payload words that must match before the CPU is released.
//
// state  | meaning
// HDR_LO | waiting for word-count low byte
// HDR_HI | waiting for word-count high byte
// DATA   | receiving payload words
// CSUM   | receiving checksum bytes (checksum build only)
// DRAIN  | last word being written, release next cycle
// RUN    | image loaded, CPU out of reset
// ERR    | load failed, CPU held in reset
module sc_boot_loader
  import sc_boot_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             reload,
  sc_boot_loader_if.slave  bus,
  output logic             cpu_resetn,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  boot_state_t       state;
  logic [7:0]        count_lo;
  logic [15:0]       word_count;
  logic [15:0]       word_idx;
  logic [ADDR_W-1:0] addr_q;

  logic        accept;
  logic        pack_en;
  logic        pack_clr;
  logic        byte_last;
  logic        word_valid;
  logic [31:0] word_data;
  logic [15:0] hdr_count;
  logic        word_last;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign pack_en   = accept && (state == DATA) && !reload;
  assign pack_clr  = reload || (state == HDR_LO) || (state == HDR_HI);
  assign hdr_count = {bus.rx_data, count_lo};
  assign word_last = (word_idx == (word_count - 16'd1));

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
  logic [31:0] sum_now;
  logic [7:0]  csum_byte;
  logic [1:0]  csum_idx;
  logic        csum_bad;

  // The last payload word may still be in flight when the first checksum
  // byte arrives, so compare against the sum including it.
  assign sum_now   = sum_q + (word_valid ? word_data : 32'd0);
  assign csum_byte = sum_now[{csum_idx, 3'b000} +: 8];

  // Running wrapping sum of every completed payload word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sum_q <= 32'd0;
    end else if (reload || (state == HDR_LO)) begin
      sum_q <= 32'd0;
    end else if (word_valid) begin
      sum_q <= sum_q + word_data;
    end
  end
`endif

  sc_byte_packer u_packer (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (pack_clr),
    .byte_en    (pack_en),
    .byte_data  (bus.rx_data),
    .byte_last  (byte_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Load sequencing, word counter and write address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= HDR_LO;
      count_lo   <= 8'd0;
      word_count <= 16'd0;
      word_idx   <= 16'd0;
      addr_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_idx   <= 2'd0;
      csum_bad   <= 1'b0;
`endif
    end else if (reload) begin
      state    <= HDR_LO;
      word_idx <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
      csum_idx <= 2'd0;
      csum_bad <= 1'b0;
`endif
    end else begin
      case (state)
        HDR_LO: begin
          if (accept) begin
            count_lo <= bus.rx_data;
            state    <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            word_count <= hdr_count;
            word_idx   <= 16'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_idx   <= 2'd0;
            csum_bad   <= 1'b0;
            if (hdr_count == 16'd0) begin
              state <= CSUM;
            end
`else
            if (hdr_count == 16'd0) begin
              state <= RUN;
            end
`endif
            else if ({1'b0, hdr_count} > CAPACITY) begin
              state <= ERR;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && byte_last) begin
            addr_q <= word_idx[ADDR_W-1:0];
            if (word_last) begin
`ifdef BOOT_CHECKSUM_EN
              state <= CSUM;
`else
              state <= DRAIN;
`endif
            end else begin
              word_idx <= word_idx + 16'd1;
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            csum_idx <= csum_idx + 2'd1;
            if (csum_idx == 2'd3) begin
              state <= (csum_bad || (bus.rx_data != csum_byte)) ? ERR : RUN;
            end else begin
              csum_bad <= csum_bad || (bus.rx_data != csum_byte);
            end
          end
        end
`endif
        DRAIN:   state <= RUN;
        RUN:     state <= RUN;
        ERR:     state <= ERR;
        default: state <= HDR_LO;
      endcase
    end
  end

  assign bus.rx_ready   = boot_rx_ready(state);
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_data;
  assign busy           = boot_busy(state);
  assign done           = (state == RUN);
  assign error          = (state == ERR);
  assign cpu_resetn     = (state == RUN);

endmodule

// File: tb/tb_sc_boot_loader.sv
`timescale 1ns/1ps
module tb_sc_boot_loader;

  localparam int ADDR_W = 6;
  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;
  localparam int K_TMO  = 3;

  // {rx_ready, imem_we, cpu_resetn, busy, done, error}
  localparam logic [5:0] ST_LOAD = 6'b100100;
  localparam logic [5:0] ST_RUN  = 6'b001010;
  localparam logic [5:0] ST_ERR  = 6'b000001;

  typedef struct {
    int                kind;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int unsigned       edge_no;
  } ev_t;

  typedef struct {
    logic [5:0]  flags;
    bit          full;
    int unsigned edge_no;
  } st_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic reload = 1'b0;
  logic cpu_resetn, busy, done, error;

  int unsigned edge_n   = 0;
  int unsigned acc_edge = 0;
  int          checks   = 0;
  int          errors   = 0;

  ev_t exp_q[$];
  st_t st_q[$];
  logic [31:0] img [0:63];

  sc_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  sc_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .reload     (reload),
    .bus        (bus),
    .cpu_resetn (cpu_resetn),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic push_ev(input int kind, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] data, input int unsigned at);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.edge_no = at;
    exp_q.push_back(e);
  endtask

  task automatic push_status(input logic [5:0] flags, input bit full);
    st_t s;
    s.flags = flags; s.full = full; s.edge_no = edge_n + 1;
    st_q.push_back(s);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        done_q  = 1'b0;
  logic        error_q = 1'b0;
  ev_t         mon_ev;
  st_t         mon_st;
  logic [5:0]  mon_act;

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event_unexpected: got kind=%0d addr=%0d data=%h at edge %0d, required no event",
               kind, bus.imem_addr, bus.imem_wdata, edge_n);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.edge_no != edge_n ||
        (kind == K_WR && (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data))) begin
      errors++;
      $display("FAIL event_compare: got kind=%0d addr=%0d data=%h edge=%0d, required kind=%0d addr=%0d data=%h edge=%0d",
               kind, bus.imem_addr, bus.imem_wdata, edge_n, e.kind, e.addr, e.data, e.edge_no);
    end
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
      mon_ev = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL event_missing: kind=%0d addr=%0d data=%h required at edge %0d, absent at edge %0d",
               mon_ev.kind, mon_ev.addr, mon_ev.data, mon_ev.edge_no, edge_n);
    end
    if (bus.imem_we === 1'b1) observe(K_WR);
    if (done === 1'b1 && done_q === 1'b0) observe(K_DONE);
    if (error === 1'b1 && error_q === 1'b0) observe(K_ERR);
    done_q  = done;
    error_q = error;
    while (st_q.size() > 0 && st_q[0].edge_no <= edge_n) begin
      mon_st  = st_q.pop_front();
      mon_act = {bus.rx_ready, bus.imem_we, cpu_resetn, busy, done, error};
      checks++;
      if (mon_act !== mon_st.flags ||
          (mon_st.full && (bus.imem_addr !== '0 || bus.imem_wdata !== 32'd0))) begin
        errors++;
        $display("FAIL status: got flags=%b addr=%0d wdata=%h, required flags=%b%s at edge %0d",
                 mon_act, bus.imem_addr, bus.imem_wdata, mon_st.flags,
                 mon_st.full ? " addr=0 wdata=0" : "", edge_n);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned guard;
    guard = 0;
    if (gap) @(negedge clock);
    @(negedge clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && guard < 32) begin
      @(negedge clock);
      guard++;
    end
    if (bus.rx_ready !== 1'b1) begin
      bus.rx_valid = 1'b0;
      push_ev(K_TMO, '0, {24'd0, b}, edge_n);
      return;
    end
    @(posedge clock);
    #1;
    acc_edge     = edge_n;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input bit gap, input bit bad_csum);
    logic [31:0] sum;
    logic [31:0] csum;
    sum = 32'd0;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int k = 0; k < n; k++) begin
      sum = sum + img[k];
      for (int b = 0; b < 4; b++) send_byte(img[k][8*b +: 8], gap);
      push_ev(K_WR, ADDR_W'(k), img[k], acc_edge);
    end
`ifdef BOOT_CHECKSUM_EN
    csum = bad_csum ? sum + 32'd1 : sum;
    for (int b = 0; b < 4; b++) send_byte(csum[8*b +: 8], gap);
    push_ev(bad_csum ? K_ERR : K_DONE, '0, 32'd0, acc_edge);
`else
    csum = sum;
    if (bad_csum || csum != sum) push_ev(K_ERR, '0, 32'd0, acc_edge);
    else if (n == 0) push_ev(K_DONE, '0, 32'd0, acc_edge);
    else push_ev(K_DONE, '0, 32'd0, acc_edge + 1);
`endif
  endtask

  task automatic reload_pulse(input bit with_byte);
    @(negedge clock);
    reload = 1'b1;
    if (with_byte) begin
      bus.rx_data  = 8'h55;
      bus.rx_valid = 1'b1;
    end
    @(negedge clock);
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [31:0] part;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;

    // reset values
    idle(3);
    push_status(ST_LOAD, 1'b1);
    idle(2);
    resetn = 1'b1;
    idle(2);

    // two words, continuous stream
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    send_image(2, 1'b0, 1'b0);
    idle(4);
    push_status(ST_RUN, 1'b0);
    idle(2);

    // same image, valid every other cycle
    reload_pulse(1'b0);
    push_status(ST_LOAD, 1'b0);
    send_image(2, 1'b1, 1'b0);
    idle(6);
    push_status(ST_RUN, 1'b0);
    idle(2);

    // empty image
    reload_pulse(1'b0);
    send_image(0, 1'b0, 1'b0);
    idle(4);
    push_status(ST_RUN, 1'b0);
    idle(2);

    // oversize count: 65 words with 64-word memory
    reload_pulse(1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    push_ev(K_ERR, '0, 32'd0, acc_edge);
    bus.rx_valid = 1'b1;
    idle(3);
    push_status(ST_ERR, 1'b0);
    idle(3);
    push_status(ST_ERR, 1'b0);
    idle(1);
    bus.rx_valid = 1'b0;

    // reload mid-word of a 3-word image, with a byte offered alongside reload
    reload_pulse(1'b0);
    part = 32'hA5A5_0001;
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(part[8*b +: 8], 1'b0);
    push_ev(K_WR, '0, part, acc_edge);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    reload_pulse(1'b1);
    push_status(ST_LOAD, 1'b0);
    img[0] = 32'hCAFE_F00D;
    send_image(1, 1'b0, 1'b0);
    idle(5);
    push_status(ST_RUN, 1'b0);
    idle(2);

    // full-capacity image: 64 words, last address 63
    for (int k = 0; k < 64; k++) img[k] = 32'(32'h9E37_79B9 * (k + 1));
    reload_pulse(1'b0);
    send_image(64, 1'b0, 1'b0);
    idle(5);
    push_status(ST_RUN, 1'b0);
    idle(2);

`ifdef BOOT_CHECKSUM_EN
    img[0] = 32'd1;
    img[1] = 32'd2;
    reload_pulse(1'b0);
    send_image(2, 1'b0, 1'b0);
    idle(4);
    push_status(ST_RUN, 1'b0);
    idle(2);
    reload_pulse(1'b0);
    send_image(2, 1'b0, 1'b1);
    idle(4);
    push_status(ST_ERR, 1'b0);
    idle(2);
`endif

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
